// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch stage: PC owner, credit-limited imem requests, decode queue
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);
    localparam int          AW    = $clog2(QDEPTH);
    localparam int          CW    = AW + 1;
    localparam logic [CW:0] LIMIT = (CW+1)'(QDEPTH);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [31:0]   pc;
    logic [CW-1:0] inflight, qcount, drop_cnt;

    logic [31:0]   tag_mem [QDEPTH];
    logic [AW-1:0] tag_wr, tag_rd;

    logic [31:0]   q_pc   [QDEPTH];
    logic [31:0]   q_inst [QDEPTH];
    logic [AW-1:0] q_wr, q_rd;

    logic accept, take_rsp, pop, q_empty;

    // Credit rule: requests in flight plus buffered entries never exceed the queue depth,
    // so every kept response is guaranteed a slot.
    assign q_empty        = (qcount == '0);
    assign imem_req_valid = rst_n & ~redirect_valid & (drop_cnt == '0)
                          & (({1'b0, inflight} + {1'b0, qcount}) < LIMIT);
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid & imem_req_ready;
    assign take_rsp       = imem_rsp_valid & (drop_cnt == '0);

    assign id_valid = rst_n & ~q_empty & ~redirect_valid;
    assign pop      = id_valid & id_ready;
    assign id_inst  = q_empty ? NOP : q_inst[q_rd];
    assign id_pc    = q_empty ? 32'h0 : q_pc[q_rd];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            inflight <= '0;
            qcount   <= '0;
            drop_cnt <= '0;
            tag_wr   <= '0;
            tag_rd   <= '0;
            q_wr     <= '0;
            q_rd     <= '0;
        end else if (redirect_valid) begin
            // Everything still outstanding returns later and must be discarded;
            // a response arriving right now is itself one of those.
            pc       <= redirect_pc;
            drop_cnt <= drop_cnt + inflight - CW'(imem_rsp_valid);
            inflight <= '0;
            qcount   <= '0;
            tag_wr   <= '0;
            tag_rd   <= '0;
            q_wr     <= '0;
            q_rd     <= '0;
        end else begin
            if (accept) begin
                tag_mem[tag_wr] <= pc;
                tag_wr          <= tag_wr + AW'(1);
                pc              <= pc + 32'd4;
            end
            if (imem_rsp_valid) begin
                if (drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end else begin
                    q_pc[q_wr]   <= tag_mem[tag_rd];
                    q_inst[q_wr] <= imem_rsp_data;
                    q_wr         <= q_wr + AW'(1);
                    tag_rd       <= tag_rd + AW'(1);
                end
            end
            if (pop) begin
                q_rd <= q_rd + AW'(1);
            end
            inflight <= inflight + CW'(accept) - CW'(take_rsp);
            qcount   <= qcount + CW'(take_rsp) - CW'(pop);
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        !(take_rsp && !redirect_valid && qcount == LIMIT[CW-1:0]));

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - directed and randomized check of if_fetch_queue against a queue-based model
`timescale 1ns/1ps
module tb_if_fetch_queue;
    localparam int QD = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, imem_req_ready, imem_rsp_valid, redirect_valid, id_ready;
    logic [31:0] imem_rsp_data, redirect_pc;
    logic        imem_req_valid, id_valid;
    logic [31:0] imem_req_addr, id_inst, id_pc;
    logic        w_req_valid, w_id_valid;
    logic [31:0] w_req_addr, w_id_inst, w_id_pc;

    if_fetch_queue #(.RESET_PC(32'h0000_0000), .QDEPTH(QD)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc)
    );

    if_fetch_queue #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(QD)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(w_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(w_id_valid), .id_ready(id_ready), .id_inst(w_id_inst), .id_pc(w_id_pc)
    );

    typedef struct packed { logic [31:0] pc; logic [31:0] inst; } entry_t;
    typedef struct packed { logic [31:0] addr; int due; } rsp_t;

    // Reference: fetch PC, outstanding kept addresses, discard count, delivered-instruction buffer
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];
    int          m_drop;
    entry_t      m_buf[$];

    rsp_t        rq[$];
    int          last_due, cyc, lat_min, lat_max;
    int          checks, errors;
    logic [31:0] acc_log[$], del_log[$], wrap_log[$];
    logic        s_rv, s_idv;
    logic [31:0] s_addr, s_inst, s_pc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_log(input string nm, input logic [31:0] q[$], input int idx, input logic [31:0] exp);
        if (idx >= q.size()) begin
            checks++;
            errors++;
            $display("FAIL %s cyc=%0d got=<none> want=%h", nm, cyc, exp);
        end else begin
            chk(nm, q[idx], exp);
        end
    endtask

    task automatic cycle();
        logic        exp_rv, exp_idv, acc;
        logic [31:0] exp_inst, exp_pc;
        entry_t      e;
        rsp_t        r;
        int          lat;
        imem_rsp_valid = (rq.size() > 0) && (rq[0].due <= cyc);
        imem_rsp_data  = imem_rsp_valid ? memf(rq[0].addr) : $urandom;
        @(negedge clk);
        exp_rv   = rst_n && !redirect_valid && m_drop == 0 && (m_pend.size() + m_buf.size() < QD);
        exp_idv  = rst_n && !redirect_valid && m_buf.size() > 0;
        exp_inst = (m_buf.size() > 0) ? m_buf[0].inst : 32'h0000_0013;
        exp_pc   = (m_buf.size() > 0) ? m_buf[0].pc : 32'h0;
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
        chk("id_valid", 32'(id_valid), 32'(exp_idv));
        chk("id_inst", id_inst, exp_inst);
        chk("id_pc", id_pc, exp_pc);
        s_rv = imem_req_valid; s_addr = imem_req_addr;
        s_idv = id_valid; s_inst = id_inst; s_pc = id_pc;
        if (imem_req_valid && imem_req_ready) acc_log.push_back(imem_req_addr);
        if (id_valid && id_ready) del_log.push_back(id_pc);
        if (w_req_valid && imem_req_ready) wrap_log.push_back(w_req_addr);

        acc = exp_rv && imem_req_ready;
        if (imem_rsp_valid) void'(rq.pop_front());
        if (acc) begin
            lat = int'($urandom_range(lat_max, lat_min));
            r.addr = m_pc;
            r.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            last_due = r.due;
            rq.push_back(r);
        end
        if (!rst_n) begin
            m_pc = 32'h0; m_drop = 0;
            m_pend.delete(); m_buf.delete();
        end else if (redirect_valid) begin
            m_drop = m_drop + m_pend.size() - (imem_rsp_valid ? 1 : 0);
            m_pend.delete(); m_buf.delete();
            m_pc = redirect_pc;
        end else begin
            if (exp_idv && id_ready) void'(m_buf.pop_front());
            if (imem_rsp_valid) begin
                if (m_drop > 0) m_drop--;
                else begin
                    e.pc = m_pend.pop_front();
                    e.inst = imem_rsp_data;
                    m_buf.push_back(e);
                end
            end
            if (acc) begin
                m_pend.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic quiesce_reset();
        int n;
        n = 0;
        imem_req_ready = 1'b0; redirect_valid = 1'b0; id_ready = 1'b1;
        while (rq.size() > 0 && n < 50) begin cycle(); n++; end
        chk("quiesce_left", 32'(rq.size()), 32'h0);
        rq.delete();
        rst_n = 1'b0;
        cycle(); cycle();
        last_due = cyc;
        acc_log.delete(); del_log.delete(); wrap_log.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        int first_v;
        checks = 0; errors = 0; cyc = 0; last_due = 0; lat_min = 1; lat_max = 1;
        rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
        m_pc = 32'h0; m_drop = 0;
        @(posedge clk); #1;
        cycle();
        chk("rst_req_valid", 32'(s_rv), 32'h0);
        chk("rst_id_valid", 32'(s_idv), 32'h0);
        chk("rst_id_inst", s_inst, 32'h0000_0013);
        chk("rst_id_pc", s_pc, 32'h0);
        acc_log.delete(); del_log.delete(); wrap_log.delete();

        // streaming, 1-cycle latency
        rst_n = 1'b1; imem_req_ready = 1'b1; id_ready = 1'b1;
        first_v = -1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (s_idv && first_v < 0) first_v = i;
        end
        chk("first_id_valid_cycle", 32'(first_v), 32'd2);
        chk_log("acc0", acc_log, 0, 32'h0);
        chk_log("acc1", acc_log, 1, 32'h4);
        chk_log("acc2", acc_log, 2, 32'h8);
        chk_log("del0", del_log, 0, 32'h0);
        chk_log("del1", del_log, 1, 32'h4);
        chk_log("del2", del_log, 2, 32'h8);
        chk_log("wrap0", wrap_log, 0, 32'hFFFF_FFF8);
        chk_log("wrap1", wrap_log, 1, 32'hFFFF_FFFC);
        chk_log("wrap2", wrap_log, 2, 32'h0000_0000);

        // decode stall
        quiesce_reset();
        imem_req_ready = 1'b1; id_ready = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        chk("stall_accepts", 32'(acc_log.size()), 32'd2);
        chk("stall_req_valid", 32'(s_rv), 32'h0);
        chk("stall_id_valid", 32'(s_idv), 32'h1);
        chk("stall_id_pc", s_pc, 32'h0);
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        chk_log("stall_del0", del_log, 0, 32'h0);
        chk_log("stall_del1", del_log, 1, 32'h4);

        // redirect with two requests in flight
        quiesce_reset();
        lat_min = 3; lat_max = 3;
        imem_req_ready = 1'b1; id_ready = 1'b1;
        cycle(); cycle();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        cycle();
        chk("redir_no_issue", 32'(s_rv), 32'h0);
        chk("redir_id_masked", 32'(s_idv), 32'h0);
        redirect_valid = 1'b0;
        acc_log.delete(); del_log.delete();
        cycle();
        chk("drop_wait1", 32'(s_rv), 32'h0);
        cycle();
        chk("drop_wait2", 32'(s_rv), 32'h0);
        for (int i = 0; i < 10; i++) cycle();
        chk_log("redir_acc0", acc_log, 0, 32'h0000_0100);
        chk_log("redir_acc1", acc_log, 1, 32'h0000_0104);
        chk_log("redir_del0", del_log, 0, 32'h0000_0100);

        // redirect coinciding with the only outstanding response
        quiesce_reset();
        lat_min = 2; lat_max = 2;
        imem_req_ready = 1'b1; id_ready = 1'b1;
        cycle();
        imem_req_ready = 1'b0;
        cycle();
        imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        chk("same_cyc_req_valid", 32'(s_rv), 32'h1);
        chk("same_cyc_req_addr", s_addr, 32'h0000_0200);

        // reset with a full queue
        quiesce_reset();
        lat_min = 1; lat_max = 1;
        imem_req_ready = 1'b1; id_ready = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        chk("full_id_valid", 32'(s_idv), 32'h1);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("post_rst_id_valid", 32'(s_idv), 32'h0);
        chk("post_rst_id_inst", s_inst, 32'h0000_0013);
        chk("post_rst_req_valid", 32'(s_rv), 32'h1);
        chk("post_rst_req_addr", s_addr, 32'h0);

        // randomized traffic
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            imem_req_ready = ($urandom % 4) != 0;
            id_ready       = ($urandom % 3) != 0;
            redirect_valid = ($urandom % 12) == 0;
            redirect_pc    = $urandom;
            cycle();
        end
        redirect_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
